// File: rtl/fir_multichannel.sv
// fir_multichannel: channel-interleaved decimating FIR filter with one shared,
// unrolled multiply-accumulate pipeline and an independent tap history per channel.
// Optional build macro FIR_SATURATE_EN: clamp the result to the output range
// instead of keeping the low DATA_SIZE bits of the accumulator.
module fir_multichannel #(
  parameter int unsigned TAPS       = 32,
  parameter int unsigned UNROLL     = 8,
  parameter int unsigned DECIMATION = 8,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned FRAC_BITS  = 10,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFF = '0,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  output logic                 x_rd_en,
  input  logic                 x_empty,
  output logic [DATA_SIZE-1:0] y_out,
  output logic [CW-1:0]        y_chan,
  output logic                 y_wr_en,
  input  logic                 y_out_full
);

  localparam int unsigned G  = TAPS / UNROLL;
  localparam int unsigned PW = 2 * DATA_SIZE;
  localparam int unsigned AW = DATA_SIZE + $clog2(TAPS);
  localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned FW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_DRAIN, S_WRITE} state_t;

  state_t state, state_next;

  logic signed [DATA_SIZE-1:0] hist      [CHANNELS][TAPS];
  logic signed [PW-1:0]        prod      [UNROLL];
  logic signed [PW-1:0]        prod_next [UNROLL];
  logic        [TW-1:0]        tap_idx   [UNROLL];
  logic signed [AW-1:0]        psum      [UNROLL];
  logic signed [AW-1:0]        acc_total;
  logic signed [DATA_SIZE-1:0] result;

  logic [CW-1:0] word_chan;
  logic [CW-1:0] cur_chan;
  logic [FW-1:0] frame_cnt;
  logic [GW-1:0] mac_cnt;
  logic          last_word;
  logic          last_chan;

  // Dequantise a full product: divide by 2^FRAC_BITS rounding toward zero.
  function automatic logic signed [DATA_SIZE-1:0] dq(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] q;
    if (p[PW-1]) q = -((-p) >>> FRAC_BITS);
    else         q = p >>> FRAC_BITS;
    return DATA_SIZE'(q);
  endfunction

  assign last_word = (word_chan == CW'(CHANNELS - 1)) && (frame_cnt == FW'(DECIMATION - 1));
  assign last_chan = (cur_chan == CW'(CHANNELS - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  // Next state and FIFO handshakes; neither handshake fires while reset is high.
  always_comb begin
    state_next = state;
    x_rd_en    = 1'b0;
    y_wr_en    = 1'b0;
    case (state)
      S_LOAD: begin
        if (!x_empty && !reset) begin
          x_rd_en = 1'b1;
          if (last_word) state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (mac_cnt == GW'(G - 1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!y_out_full && !reset) begin
          y_wr_en    = 1'b1;
          state_next = last_chan ? S_LOAD : S_MAC;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // Product group for the current MAC cycle: taps mac_cnt*UNROLL .. +UNROLL-1.
  always_comb begin
    for (int u = 0; u < UNROLL; u++) begin
      tap_idx[u]   = TW'(mac_cnt * UNROLL + u);
      prod_next[u] = PW'(signed'(COEFF[TW'(TAPS - 1) - tap_idx[u]])) *
                     PW'(hist[cur_chan][tap_idx[u]]);
    end
  end

  // Reduction of partial sums plus the registered (final) product group.
  always_comb begin
    acc_total = '0;
    for (int u = 0; u < UNROLL; u++) begin
      acc_total = acc_total + psum[u] + AW'(dq(prod[u]));
    end
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  // Clamp the accumulator into the output range.
  always_comb begin
    if (acc_total > SAT_MAX)      result = DATA_SIZE'(SAT_MAX);
    else if (acc_total < SAT_MIN) result = DATA_SIZE'(SAT_MIN);
    else                          result = DATA_SIZE'(acc_total);
  end
`else
  // Two's-complement wrap: keep the low DATA_SIZE bits.
  always_comb begin
    result = DATA_SIZE'(acc_total);
  end
`endif

  // Histories, counters, MAC pipeline and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) hist[c][k] <= '0;
      end
      for (int u = 0; u < UNROLL; u++) begin
        prod[u] <= '0;
        psum[u] <= '0;
      end
      word_chan <= '0;
      cur_chan  <= '0;
      frame_cnt <= '0;
      mac_cnt   <= '0;
      y_out     <= '0;
      y_chan    <= '0;
    end else begin
      if (x_rd_en) begin
        hist[word_chan][0] <= x_in;
        for (int k = 1; k < TAPS; k++) hist[word_chan][k] <= hist[word_chan][k-1];
        if (word_chan == CW'(CHANNELS - 1)) begin
          word_chan <= '0;
          if (!last_word) frame_cnt <= frame_cnt + FW'(1);
        end else begin
          word_chan <= word_chan + CW'(1);
        end
      end

      if (state == S_MAC) begin
        for (int u = 0; u < UNROLL; u++) prod[u] <= prod_next[u];
        if (mac_cnt != '0) begin
          for (int u = 0; u < UNROLL; u++) psum[u] <= psum[u] + AW'(dq(prod[u]));
        end
        mac_cnt <= (mac_cnt == GW'(G - 1)) ? '0 : mac_cnt + GW'(1);
      end

      if (state == S_DRAIN) begin
        y_out  <= result;
        y_chan <= cur_chan;
      end

      if (y_wr_en) begin
        for (int u = 0; u < UNROLL; u++) psum[u] <= '0;
        if (last_chan) begin
          cur_chan  <= '0;
          frame_cnt <= '0;
        end else begin
          cur_chan <= cur_chan + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_multichannel.sv
// tb_fir_multichannel: self-checking bench for fir_multichannel.
// Two instances: A (32-bit, ramp coefficients, G=2) and B (16-bit, flat
// coefficients, G=4). Expected outputs come from a direct evaluation of the
// filter equation over per-channel sample histories kept in the bench.
module tb_fir_multichannel;

  localparam int unsigned TAPS = 8;
  localparam int unsigned DEC  = 2;
  localparam int unsigned CH   = 2;

  localparam logic [0:TAPS-1][31:0] COEFF_A = {32'd1024, 32'd2048, 32'd3072, 32'd4096,
                                               32'd5120, 32'd6144, 32'd7168, 32'd8192};
  localparam logic [0:TAPS-1][15:0] COEFF_B = {8{16'd1024}};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x_in_a;
  logic [15:0] x_in_b;
  logic [1:0]  x_empty;
  logic [1:0]  y_out_full;
  logic [1:0]  x_rd_en;
  logic [1:0]  y_wr_en;
  logic [1:0]  y_chan;
  logic [31:0] y_out_a;
  logic [15:0] y_out_b;

  longint hist [2][CH][TAPS];
  int     wc [2];
  int     n_checks = 0;
  int     n_pass   = 0;

  always #5 clk = ~clk;

  fir_multichannel #(
    .TAPS(TAPS), .UNROLL(4), .DECIMATION(DEC), .CHANNELS(CH),
    .DATA_SIZE(32), .FRAC_BITS(10), .COEFF(COEFF_A)
  ) dut_a (
    .clock(clk), .reset(reset), .x_in(x_in_a), .x_rd_en(x_rd_en[0]),
    .x_empty(x_empty[0]), .y_out(y_out_a), .y_chan(y_chan[0]),
    .y_wr_en(y_wr_en[0]), .y_out_full(y_out_full[0])
  );

  fir_multichannel #(
    .TAPS(TAPS), .UNROLL(2), .DECIMATION(DEC), .CHANNELS(CH),
    .DATA_SIZE(16), .FRAC_BITS(10), .COEFF(COEFF_B)
  ) dut_b (
    .clock(clk), .reset(reset), .x_in(x_in_b), .x_rd_en(x_rd_en[1]),
    .x_empty(x_empty[1]), .y_out(y_out_b), .y_chan(y_chan[1]),
    .y_wr_en(y_wr_en[1]), .y_out_full(y_out_full[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int gsz(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int dsz(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic longint coef(input int d, input int j);
    return (d == 0) ? longint'((j + 1) * 1024) : 64'sd1024;
  endfunction

  // Reinterpret the low ds bits of v as a signed ds-bit number.
  function automatic longint sext(input longint v, input int ds);
    longint m, r;
    m = longint'(1) << ds;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  // y[c] = sum_k DQ(COEFF[TAPS-1-k] * h[c][k]); '/' truncates toward zero.
  function automatic longint ref_y(input int d, input int c);
    longint acc, p, lim;
    int ds;
    ds  = dsz(d);
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      p   = coef(d, TAPS - 1 - k) * hist[d][c][k];
      acc = acc + sext(p / 1024, ds);
    end
`ifdef FIR_SATURATE_EN
    lim = longint'(1) << (ds - 1);
    if (acc > lim - 1) acc = lim - 1;
    else if (acc < -lim) acc = -lim;
`else
    lim = 0;
    acc = sext(acc + lim, ds);
`endif
    return acc;
  endfunction

  function automatic longint rnd(input int d);
    int r;
    r = $urandom();
    return (d == 0) ? longint'(r) : longint'(shortint'(r));
  endfunction

  function automatic longint get_y(input int d);
    return (d == 0) ? longint'(signed'(y_out_a)) : longint'(signed'(y_out_b));
  endfunction

  function automatic void clear_model();
    for (int d = 0; d < 2; d++) begin
      wc[d] = 0;
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < TAPS; k++) hist[d][c][k] = 0;
    end
  endfunction

  // Offer one word (optionally after one empty cycle); entered and left at a negedge.
  task automatic send_word(input int d, input longint v, input bit gap);
    int c;
    if (gap) begin
      x_empty[d] = 1'b1;
      #1 check("no_pop_when_empty", x_rd_en[d], 0);
      @(negedge clk);
    end
    if (d == 0) x_in_a = 32'(v);
    else        x_in_b = 16'(v);
    x_empty[d] = 1'b0;
    #1 check("pop_when_ready", x_rd_en[d], 1);
    @(posedge clk);
    c = wc[d] % CH;
    for (int k = TAPS - 1; k > 0; k--) hist[d][c][k] = hist[d][c][k-1];
    hist[d][c][0] = v;
    wc[d]++;
    @(negedge clk);
  endtask

  // One decimation period of words: mode 0 impulse, 1 random, 2 per-channel constants.
  task automatic send_set(input int d, input int mode, input int fs,
                          input longint c0, input longint c1, input bit gap);
    longint v;
    for (int w = 0; w < DEC * CH; w++) begin
      case (mode)
        0:       v = (fs == 0 && w == 0) ? 64'sd1 : 64'sd0;
        1:       v = rnd(d);
        default: v = ((w % CH) == 0) ? c0 : c1;
      endcase
      send_word(d, v, gap);
    end
    x_empty[d] = 1'b1;
  endtask

  // Expect one push per channel in order; optional back-pressure on channel 0.
  task automatic collect(input int d, input bit bp, input bit lat);
    longint e;
    int waited;
    for (int c = 0; c < CH; c++) begin
      e = ref_y(d, c);
      if (bp && c == 0) begin
        y_out_full[d] = 1'b1;
        for (int i = 0; i < gsz(d) + 6; i++) begin
          #1 check("no_push_when_full", y_wr_en[d], 0);
          if (i > gsz(d)) begin
            check("hold_y_out", get_y(d), e);
            check("hold_y_chan", y_chan[d], 0);
          end
          @(negedge clk);
        end
        y_out_full[d] = 1'b0;
      end
      waited = 0;
      #1;
      while (y_wr_en[d] !== 1'b1 && waited < 60) begin
        @(negedge clk);
        #1;
        waited++;
      end
      check("push_timeout", longint'(waited < 60), 1);
      if (lat && !(bp && c == 0)) check("push_latency", waited, gsz(d) + 1);
      check("y_chan", y_chan[d], c);
      check("y_out", get_y(d), e);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1 check("no_extra_push", y_wr_en[d], 0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    x_empty    = 2'b11;
    y_out_full = 2'b00;
    x_in_a     = '0;
    x_in_b     = '0;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_x_rd_en", x_rd_en[d], 0);
      check("reset_y_wr_en", y_wr_en[d], 0);
      check("reset_y_out", get_y(d), 0);
      check("reset_y_chan", y_chan[d], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Impulse on ch0 of A: 7, 5, 3, 1, 0, 0; ch1 stays 0.
    for (int fs = 0; fs < 6; fs++) begin
      send_set(0, 0, fs, 0, 0, 1'b0);
      collect(0, 1'b0, 1'b1);
    end

    // Random samples on A.
    for (int fs = 0; fs < 4; fs++) begin
      send_set(0, 1, fs, 0, 0, 1'b0);
      collect(0, 1'b0, 1'b1);
    end

    // Input starvation: empty on every other cycle.
    for (int fs = 0; fs < 3; fs++) begin
      send_set(0, 1, fs, 0, 0, 1'b1);
      collect(0, 1'b0, 1'b1);
    end

    // Output back-pressure on A.
    send_set(0, 1, 0, 0, 0, 1'b0);
    collect(0, 1'b1, 1'b1);

    // Reset after 3 of 4 words of a set, with a word still on offer.
    for (int w = 0; w < 3; w++) send_word(0, rnd(0), 1'b0);
    reset      = 1'b1;
    x_empty[0] = 1'b0;
    #1;
    check("no_pop_in_reset", x_rd_en[0], 0);
    check("no_push_in_reset_a", y_wr_en[0], 0);
    @(negedge clk);
    #1;
    check("midframe_reset_y_out", get_y(0), 0);
    check("midframe_reset_y_chan", y_chan[0], 0);
    reset      = 1'b0;
    x_empty[0] = 1'b1;
    clear_model();
    @(negedge clk);
    send_set(0, 1, 0, 0, 0, 1'b0);
    collect(0, 1'b0, 1'b1);

    // DC on B: +100 / -100 settles to 800 / -800.
    for (int fs = 0; fs < 5; fs++) begin
      send_set(1, 2, fs, 100, -100, 1'b0);
      collect(1, 1'b0, 1'b1);
    end

    // Overflow on B: full-scale inputs.
    for (int fs = 0; fs < 5; fs++) begin
      send_set(1, 2, fs, 32767, -32768, 1'b0);
      collect(1, 1'b0, 1'b1);
    end

    // Random and back-pressure on B.
    for (int fs = 0; fs < 3; fs++) begin
      send_set(1, 1, fs, 0, 0, 1'b0);
      collect(1, 1'b0, 1'b1);
    end
    send_set(1, 1, 0, 0, 0, 1'b0);
    collect(1, 1'b1, 1'b1);

    // Reset while B waits in WRITE: no push in the reset cycle.
    send_set(1, 1, 0, 0, 0, 1'b0);
    y_out_full[1] = 1'b1;
    repeat (gsz(1) + 2) @(negedge clk);
    #1 check("write_value_before_reset", get_y(1), ref_y(1, 0));
    reset         = 1'b1;
    y_out_full[1] = 1'b0;
    #1 check("no_push_in_reset_b", y_wr_en[1], 0);
    @(negedge clk);
    #1;
    check("write_reset_y_out", get_y(1), 0);
    check("write_reset_y_wr_en", y_wr_en[1], 0);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    send_set(1, 1, 0, 0, 0, 1'b0);
    collect(1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_multichannel.md
# fir_multichannel

Parameterised multi-channel decimating FIR filter for the FM radio datapath. It reads channel-interleaved samples from one input FIFO and keeps an independent tap history per channel. Every DECIMATION frames it computes one filtered output per channel using a shared, unrolled multiply-accumulate pipeline, then writes the results channel-interleaved to one output FIFO. It replaces separate per-channel FIR instances wherever several streams share a sample rate and coefficient set, for example stereo L+R / L−R filtering.

## Interface
- TAPS, 32: filter length; must be a multiple of UNROLL.
- UNROLL, 8: multipliers per MAC cycle; G = TAPS/UNROLL MAC cycles per channel.
- DECIMATION, 8: input frames consumed per output frame; ≥1.
- CHANNELS, 2: interleaved channels; ≥1.
- DATA_SIZE, 32: signed sample, coefficient and output width.
- FRAC_BITS, 10: coefficient fractional bits removed by dequantisation.
- COEFF, '0: [0:TAPS-1][DATA_SIZE-1:0] signed coefficient set, shared by all channels.
- clock  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- x_in  in  DATA_SIZE  input FIFO data; word order ch0, ch1, …, ch(CHANNELS-1), repeating.
- x_rd_en  out  1  input FIFO pop.
- x_empty  in  1  input FIFO empty.
- y_out  out  DATA_SIZE  filtered sample.
- y_chan  out  max(1,$clog2(CHANNELS))  channel index of y_out.
- y_wr_en  out  1  output FIFO push.
- y_out_full  in  1  output FIFO full.

## Operation
- Per-channel history h[c][0:TAPS-1]; h[c][0] is the newest sample.
- Output per channel: y[c] = Σk DQ(COEFF[TAPS-1-k] × h[c][k]), for k = 0 … TAPS-1.
- Product: full 2·DATA_SIZE signed.
- DQ: divide by 2^FRAC_BITS with rounding toward zero (negate, arithmetic-shift, negate for negative values), then truncate to DATA_SIZE.
- Accumulator width: DATA_SIZE + $clog2(TAPS), signed.
- States: LOAD → MAC → DRAIN → WRITE, then back to MAC for the next channel or to LOAD after the last channel.
- LOAD:
  - When !x_empty: x_rd_en=1 and x_in shifts into h[word_chan].
  - word_chan wraps at CHANNELS; frame_cnt increments when word_chan wraps.
  - After the last word of frame DECIMATION-1: go to MAC with cur_chan=0.
  - When x_empty: hold with no pop.
- MAC: G cycles. In cycle g, UNROLL products for taps g·UNROLL … g·UNROLL+UNROLL-1 are registered; the products from cycle g-1 are DQ'd and added into UNROLL partial sums.
- DRAIN: 1 cycle. The final product group is accumulated and the partial sums are reduced into result.
- WRITE:
  - y_out = result (after the FIR_SATURATE_EN rule) and y_chan = cur_chan, both registered.
  - y_wr_en = !y_out_full, combinational in this state.
  - On a push: partial sums clear; cur_chan increments, or the block returns to LOAD after the last channel with frame_cnt=0.
- Histories persist across output frames. Only reset clears them.

## Timing
- Reset values: state=LOAD, x_rd_en=0, y_wr_en=0, y_out=0, y_chan=0, all histories, sums and counters 0.
- Throughput in LOAD: one pop per cycle.
- Final pop of a frame set at cycle t:
  - MAC occupies t+1 … t+G.
  - DRAIN occupies t+G+1.
  - The earliest ch0 push is at t+G+2.
- Each further channel adds G+2 cycles when unstalled.
- Back-pressure: y_out_full holds WRITE with y_out/y_chan stable. No data is lost or duplicated.
- x_rd_en is 0 outside LOAD; y_wr_en is 0 outside WRITE. The block never pops and pushes in the same cycle.
- Reset in any state, including mid-frame or mid-WRITE:
  - Takes effect at the next edge and discards the partial frame.
  - No push occurs in the reset cycle.
- CHANNELS=1: y_chan is a constant 0 and the channel wrap is trivial.

## Configuration
- FIR_SATURATE_EN defined: result clamps to [−2^(DATA_SIZE-1), 2^(DATA_SIZE-1)−1] when reduced from accumulator width.
- FIR_SATURATE_EN undefined: result is the low DATA_SIZE bits of the accumulator (two's-complement wrap).

## Test plan
- Impulse:
  - Setup: TAPS=8, UNROLL=4, DECIMATION=2, CHANNELS=2, COEFF[j]=(j+1)·1024. ch0 gets 1 then zeros; ch1 gets all zeros.
  - Required: ch0 outputs 7, 5, 3, 1, 0; ch1 outputs always 0; y_chan alternates 0, 1.
- DC:
  - Setup: all COEFF=1024; ch0 constant 100, ch1 constant −100.
  - Required: after history fills, steady outputs 800 and −800. Each −100 term is DQ'd toward zero before summing.
- Back-pressure: hold y_out_full=1 for 5 cycles in WRITE → y_wr_en=0, y_out/y_chan stable, then exactly one push per channel with no drops.
- Input starvation: x_empty toggles each cycle → pops occur only when x_empty=0, and outputs are identical to the unstalled run.
- Overflow:
  - Setup: DATA_SIZE=16, all COEFF=1024, input 32767.
  - Required: 32767 with FIR_SATURATE_EN defined; the wrapped low 16 bits without it.
- Reset mid-frame: assert reset after 3 of 4 words of a frame set → y_wr_en=0 and y_out=0 the next cycle, histories cleared, and the next result is computed from post-reset samples only.
